// File: rtl/noc_arb_serial_sender.sv
// noc_arb_serial_sender: multi-channel NoC injector. Each channel posts one
// packet into a depth-1 holding register; an arbiter picks one channel at a
// time and serialises it as head + NB body flits on the single up port.
// Optional macro NOC_SENDER_RR_EN: round-robin arbitration when defined,
// fixed priority (lowest channel index wins) otherwise.
module noc_arb_serial_sender #(
   parameter int NUM_CH       = 2,
   parameter int PACKET_BITS  = 64,
   parameter int PADDING_BITS = 4,
   parameter int FLIT_W       = 34,
   parameter int ADDR_BITS    = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_CH-1:0]              enable,
   input  logic [NUM_CH*ADDR_BITS-1:0]    dst_addr,
   input  logic [NUM_CH*PADDING_BITS-1:0] padding,
   input  logic [NUM_CH*PACKET_BITS-1:0]  packet,
   input  logic [NUM_CH-1:0]              flush,
   output logic [NUM_CH-1:0]              ready,
   output logic [NUM_CH-1:0]              ack,
   output logic [NUM_CH-1:0]              overflow,
   output logic [FLIT_W-1:0]              up_flit,
   output logic                           up_valid,
   input  logic                           up_ready
);
   localparam int PW        = FLIT_W - 2;
   localparam int CH_BITS   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int BODY_BITS = PACKET_BITS + PADDING_BITS;
   localparam int NB        = (BODY_BITS + PW - 1) / PW;
   localparam int DATA_W    = NB * PW;

   if ((ADDR_BITS + CH_BITS + 8 > PW) || (NB > 255)) begin : g_cfg_check
      $error("noc_arb_serial_sender: head fields exceed flit payload or NB > 255");
   end

   typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;
   state_t state_q, state_d;

   logic [NUM_CH-1:0]    pending;
   logic [ADDR_BITS-1:0] hold_dst  [NUM_CH];
   logic [BODY_BITS-1:0] hold_body [NUM_CH];
   logic [NUM_CH-1:0]    eligible;
   logic                 any_elig;
   logic [CH_BITS-1:0]   gnt_idx;
   logic [CH_BITS-1:0]   cur_ch;
   logic [DATA_W-1:0]    data_q;
   logic [7:0]           beat_q;
   logic [7:0]           beat_nxt;
   logic                 last_beat;
   logic                 load_head;
   logic                 load_body;
   logic                 tail_done;
   logic [PW-1:0]        head_pl;

   // Capture requests into free holding registers; release on grant or flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending  <= '0;
         overflow <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            hold_dst[i]  <= '0;
            hold_body[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (enable[i] && pending[i])
               overflow[i] <= 1'b1;
            if (enable[i] && !pending[i]) begin
               pending[i]   <= 1'b1;
               hold_dst[i]  <= dst_addr[i*ADDR_BITS +: ADDR_BITS];
               hold_body[i] <= {packet[i*PACKET_BITS +: PACKET_BITS],
                                padding[i*PADDING_BITS +: PADDING_BITS]};
            end else if ((load_head && (gnt_idx == CH_BITS'(i))) || flush[i]) begin
               pending[i] <= 1'b0;
            end
         end
      end
   end

   assign ready    = ~pending;
   assign eligible = pending & ~flush;

`ifdef NOC_SENDER_RR_EN
   logic [CH_BITS-1:0] rr_ptr;

   // Round-robin pick: first eligible channel at or after the pointer.
   always_comb begin : p_rr_pick
      int unsigned idx;
      idx      = 0;
      gnt_idx  = '0;
      any_elig = 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         idx = (32'(rr_ptr) + k) % NUM_CH;
         if (!any_elig && eligible[idx]) begin
            any_elig = 1'b1;
            gnt_idx  = CH_BITS'(idx);
         end
      end
   end

   // Pointer moves to the channel after the one just granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr_ptr <= '0;
      else if (load_head)
         rr_ptr <= (gnt_idx == CH_BITS'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
   end
`else
   // Fixed priority pick: lowest eligible channel index wins.
   always_comb begin
      gnt_idx  = '0;
      any_elig = 1'b0;
      for (int unsigned k = NUM_CH; k > 0; k--) begin
         if (eligible[k-1]) begin
            any_elig = 1'b1;
            gnt_idx  = CH_BITS'(k - 1);
         end
      end
   end
`endif

   assign last_beat = (beat_q == 8'(NB - 1));

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // FSM next state: tail accept with a waiting channel goes straight to HEAD.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_elig) state_d = HEAD;
         HEAD:    if (up_ready) state_d = BODY;
         BODY:    if (up_ready && last_beat) state_d = any_elig ? HEAD : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM control outputs driving the serializer registers.
   always_comb begin
      load_head = 1'b0;
      load_body = 1'b0;
      tail_done = 1'b0;
      beat_nxt  = beat_q + 8'd1;
      case (state_q)
         IDLE: load_head = any_elig;
         HEAD: begin
            load_body = up_ready;
            beat_nxt  = '0;
         end
         BODY: begin
            if (up_ready) begin
               if (last_beat) begin
                  tail_done = 1'b1;
                  load_head = any_elig;
               end else begin
                  load_body = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Head flit payload: dst, source channel, body flit count, zero fill.
   always_comb begin
      head_pl                                = '0;
      head_pl[ADDR_BITS-1:0]                 = hold_dst[gnt_idx];
      head_pl[ADDR_BITS +: CH_BITS]          = gnt_idx;
      head_pl[ADDR_BITS + CH_BITS +: 8]      = 8'(NB);
   end

   // Registered flit output, LSB-first body shifter and completion ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         up_flit  <= '0;
         up_valid <= 1'b0;
         data_q   <= '0;
         beat_q   <= '0;
         cur_ch   <= '0;
         ack      <= '0;
      end else begin
         ack <= '0;
         if (tail_done)
            ack[cur_ch] <= 1'b1;
         if (load_head) begin
            up_valid <= 1'b1;
            up_flit  <= {1'b1, 1'b0, head_pl};
            data_q   <= DATA_W'(hold_body[gnt_idx]);
            cur_ch   <= gnt_idx;
         end else if (load_body) begin
            up_flit <= {1'b0, (beat_nxt == 8'(NB - 1)), data_q[PW-1:0]};
            data_q  <= data_q >> PW;
            beat_q  <= beat_nxt;
         end else if (tail_done) begin
            up_valid <= 1'b0;
            up_flit  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_noc_arb_serial_sender.sv
// Self-checking bench for noc_arb_serial_sender with default parameters.
// Expected flits come from a packet-level model (field packing and
// LSB-first slicing with plain arithmetic) plus a grant-order model.
`timescale 1ns/1ps
module tb_noc_arb_serial_sender;
   localparam int NUM_CH       = 2;
   localparam int PACKET_BITS  = 64;
   localparam int PADDING_BITS = 4;
   localparam int FLIT_W       = 34;
   localparam int ADDR_BITS    = 4;
   localparam int PW           = FLIT_W - 2;
   localparam int CHB          = 1;
   localparam int NB           = (PACKET_BITS + PADDING_BITS + PW - 1) / PW;

   logic                           clk;
   logic                           rst;
   logic [NUM_CH-1:0]              enable;
   logic [NUM_CH*ADDR_BITS-1:0]    dst_addr;
   logic [NUM_CH*PADDING_BITS-1:0] padding;
   logic [NUM_CH*PACKET_BITS-1:0]  packet;
   logic [NUM_CH-1:0]              flush;
   logic [NUM_CH-1:0]              ready;
   logic [NUM_CH-1:0]              ack;
   logic [NUM_CH-1:0]              overflow;
   logic [FLIT_W-1:0]              up_flit;
   logic                           up_valid;
   logic                           up_ready;

   noc_arb_serial_sender #(
      .NUM_CH(NUM_CH), .PACKET_BITS(PACKET_BITS), .PADDING_BITS(PADDING_BITS),
      .FLIT_W(FLIT_W), .ADDR_BITS(ADDR_BITS)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .dst_addr(dst_addr), .padding(padding),
      .packet(packet), .flush(flush), .ready(ready), .ack(ack), .overflow(overflow),
      .up_flit(up_flit), .up_valid(up_valid), .up_ready(up_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int                n_checks = 0;
   int                n_fail   = 0;
   logic [FLIT_W-1:0] got_q[$];
   logic [FLIT_W-1:0] exp_q[$];
   logic [NUM_CH-1:0] ack_or;
   int                rr_ptr = 0;

   function automatic logic [FLIT_W-1:0] exp_head(input int ch, input logic [3:0] dst);
      return (34'd1 << 33) | (34'(NB) << (ADDR_BITS + CHB)) | (34'(ch) << ADDR_BITS) | 34'(dst);
   endfunction

   function automatic logic [FLIT_W-1:0] exp_body(input logic [63:0] pkt, input logic [3:0] pad, input int k);
      logic [NB*PW-1:0] all;
      logic [PW-1:0]    chunk;
      all   = {28'd0, pkt, pad};
      chunk = PW'(all >> (PW * k));
      return {1'b0, (k == NB - 1), chunk};
   endfunction

   function automatic int first_of_pair();
`ifdef NOC_SENDER_RR_EN
      return rr_ptr;
`else
      return 0;
`endif
   endfunction

   task automatic push_pkt(input int ch, input logic [3:0] dst, input logic [3:0] pad, input logic [63:0] pkt);
      exp_q.push_back(exp_head(ch, dst));
      for (int k = 0; k < NB; k++) exp_q.push_back(exp_body(pkt, pad, k));
      rr_ptr = (ch + 1) % NUM_CH;
   endtask

   task automatic drive_req(input int ch, input logic [3:0] dst, input logic [3:0] pad, input logic [63:0] pkt);
      enable[ch]                                 = 1'b1;
      dst_addr[ch*ADDR_BITS +: ADDR_BITS]        = dst;
      padding[ch*PADDING_BITS +: PADDING_BITS]   = pad;
      packet[ch*PACKET_BITS +: PACKET_BITS]      = pkt;
   endtask

   // Called at a negedge: sets up_ready for the next posedge, logs the flit
   // that will be accepted there, then advances to the following negedge.
   task automatic tick(input logic rdy);
      up_ready = rdy;
      if (up_valid && rdy) got_q.push_back(up_flit);
      @(negedge clk);
      ack_or |= ack;
   endtask

   task automatic clear_logs();
      got_q.delete();
      exp_q.delete();
      ack_or = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (ready !== 2'b11) begin n_fail++; $display("FAIL reset_ready: got %b want 11", ready); end
      n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b want 00", ack); end
      n_checks++; if (overflow !== 2'b00) begin n_fail++; $display("FAIL reset_overflow: got %b want 00", overflow); end
      n_checks++; if (up_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", up_valid); end
      n_checks++; if (up_flit !== '0) begin n_fail++; $display("FAIL reset_flit: got %h want 0", up_flit); end
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (up_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid: got %b want 0", up_valid); end
   endtask

   task automatic test_single();
      for (int n = 0; n < 5; n++) begin
         int          ch;
         logic [3:0]  dst, pad;
         logic [63:0] pkt;
         if (n == 0) begin
            ch = 0; dst = 4'h5; pad = 4'hA; pkt = 64'h0123456789ABCDEF;
         end else begin
            ch = int'($urandom_range(1, 0)); dst = 4'($urandom); pad = 4'($urandom); pkt = {$urandom, $urandom};
         end
         clear_logs();
         push_pkt(ch, dst, pad, pkt);
         drive_req(ch, dst, pad, pkt);
         tick(1'b1);
         enable = '0;
         n_checks++; if (up_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid[%0d]: got %b want 0", n, up_valid); end
         n_checks++; if (ready[ch] !== 1'b0) begin n_fail++; $display("FAIL single_ready_busy[%0d]: got %b want 0", n, ready[ch]); end
         tick(1'b1);
         n_checks++; if (up_valid !== 1'b1) begin n_fail++; $display("FAIL single_head_valid[%0d]: got %b want 1", n, up_valid); end
         n_checks++; if (up_flit !== exp_q[0]) begin n_fail++; $display("FAIL single_head_flit[%0d]: got %h want %h", n, up_flit, exp_q[0]); end
         n_checks++; if (ready[ch] !== 1'b1) begin n_fail++; $display("FAIL single_ready_free[%0d]: got %b want 1", n, ready[ch]); end
         repeat (4) tick(1'b1);
         n_checks++; if (up_valid !== 1'b0) begin n_fail++; $display("FAIL single_end_valid[%0d]: got %b want 0", n, up_valid); end
         n_checks++; if (ack !== 2'(1 << ch)) begin n_fail++; $display("FAIL single_ack[%0d]: got %b want %b", n, ack, 2'(1 << ch)); end
         tick(1'b1);
         n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL single_ack_pulse[%0d]: got %b want 00", n, ack); end
         n_checks++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL single_count[%0d]: got %0d want 4", n, got_q.size()); end
         for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_flit[%0d.%0d]: got %h want %h", n, i, got_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [3:0]        dst, pad;
      logic [63:0]       pkt;
      logic [FLIT_W-1:0] held;
      int                stall_left, budget;
      dst = 4'($urandom); pad = 4'($urandom); pkt = {$urandom, $urandom};
      held = '0;
      clear_logs();
      push_pkt(1, dst, pad, pkt);
      drive_req(1, dst, pad, pkt);
      tick(1'b1);
      enable = '0;
      stall_left = 3;
      budget = 0;
      while (got_q.size() < 4 && budget < 60) begin
         budget++;
         if (got_q.size() == 2 && up_valid && stall_left > 0) begin
            if (stall_left == 3) held = up_flit;
            stall_left--;
            tick(1'b0);
            n_checks++; if (up_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold: got %b want 1", up_valid); end
            n_checks++; if (up_flit !== held) begin n_fail++; $display("FAIL bp_flit_stable: got %h want %h", up_flit, held); end
         end else begin
            tick($urandom_range(3, 0) != 0);
         end
      end
      repeat (3) tick(1'b1);
      n_checks++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", got_q.size()); end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_flit[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (ack_or !== 2'b10) begin n_fail++; $display("FAIL bp_ack: got %b want 10", ack_or); end
      n_checks++; if (up_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got %b want 0", up_valid); end
   endtask

   task automatic test_contention();
      for (int p = 0; p < 2; p++) begin
         logic [3:0]  dst[2], pad[2];
         logic [63:0] pkt[2];
         int          first, span, budget;
         bit          started;
         for (int c = 0; c < 2; c++) begin
            dst[c] = 4'($urandom); pad[c] = 4'($urandom); pkt[c] = {$urandom, $urandom};
         end
         clear_logs();
         first = first_of_pair();
         push_pkt(first, dst[first], pad[first], pkt[first]);
         push_pkt(1 - first, dst[1-first], pad[1-first], pkt[1-first]);
         drive_req(0, dst[0], pad[0], pkt[0]);
         drive_req(1, dst[1], pad[1], pkt[1]);
         tick(1'b1);
         enable = '0;
         span = 0; budget = 0; started = 1'b0;
         while (got_q.size() < 8 && budget < 40) begin
            budget++;
            if (up_valid) started = 1'b1;
            if (started) span++;
            tick(1'b1);
         end
         repeat (2) tick(1'b1);
         n_checks++; if (got_q.size() !== 8) begin n_fail++; $display("FAIL cont_count[%0d]: got %0d want 8", p, got_q.size()); end
         n_checks++; if (span !== 8) begin n_fail++; $display("FAIL cont_back_to_back[%0d]: span %0d want 8", p, span); end
         for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL cont_flit[%0d.%0d]: got %h want %h", p, i, got_q[i], exp_q[i]); end
         end
         n_checks++; if (ack_or !== 2'b11) begin n_fail++; $display("FAIL cont_ack[%0d]: got %b want 11", p, ack_or); end
      end
   endtask

   task automatic test_flush();
      logic [3:0]  d0, p0, d1, p1;
      logic [63:0] k0, k1;
      d0 = 4'($urandom); p0 = 4'($urandom); k0 = {$urandom, $urandom};
      d1 = 4'($urandom); p1 = 4'($urandom); k1 = {$urandom, $urandom};
      clear_logs();
      push_pkt(0, d0, p0, k0);
      drive_req(0, d0, p0, k0);
      tick(1'b1);
      enable = '0;
      tick(1'b1);
      drive_req(1, d1, p1, k1);
      tick(1'b1);
      enable = '0;
      n_checks++; if (ready[1] !== 1'b0) begin n_fail++; $display("FAIL flush_queued: ready1 %b want 0", ready[1]); end
      flush = 2'b11;
      tick(1'b1);
      flush = '0;
      n_checks++; if (ready[1] !== 1'b1) begin n_fail++; $display("FAIL flush_ready: ready1 %b want 1", ready[1]); end
      repeat (8) tick(1'b1);
      n_checks++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL flush_count: got %0d want 4", got_q.size()); end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL flush_flit[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (ack_or !== 2'b01) begin n_fail++; $display("FAIL flush_ack: got %b want 01", ack_or); end
   endtask

   task automatic test_overflow();
      logic [3:0]  d1, p1, d0, p0;
      logic [63:0] k1, k0;
      int          budget;
      d1 = 4'($urandom); p1 = 4'($urandom); k1 = {$urandom, $urandom};
      d0 = 4'($urandom); p0 = 4'($urandom); k0 = {$urandom, $urandom};
      clear_logs();
      push_pkt(1, d1, p1, k1);
      push_pkt(0, d0, p0, k0);
      drive_req(1, d1, p1, k1);
      tick(1'b1);
      enable = '0;
      drive_req(0, d0, p0, k0);
      tick(1'b1);
      enable = '0;
      n_checks++; if (overflow !== 2'b00) begin n_fail++; $display("FAIL ovf_clear: got %b want 00", overflow); end
      drive_req(0, ~d0, ~p0, ~k0);
      tick(1'b1);
      n_checks++; if (overflow !== 2'b01) begin n_fail++; $display("FAIL ovf_set: got %b want 01", overflow); end
      drive_req(0, d0 ^ 4'h3, p0, k0 ^ 64'hFFFF);
      tick(1'b1);
      enable = '0;
      budget = 0;
      while (got_q.size() < 8 && budget < 40) begin
         budget++;
         tick(1'b1);
      end
      repeat (3) tick(1'b1);
      n_checks++; if (overflow !== 2'b01) begin n_fail++; $display("FAIL ovf_sticky: got %b want 01", overflow); end
      n_checks++; if (got_q.size() !== 8) begin n_fail++; $display("FAIL ovf_count: got %0d want 8", got_q.size()); end
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_flit[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (ack_or !== 2'b11) begin n_fail++; $display("FAIL ovf_ack: got %b want 11", ack_or); end
   endtask

   task automatic test_reset_mid();
      logic [3:0]  dst, pad;
      logic [63:0] pkt;
      clear_logs();
      drive_req(1, 4'($urandom), 4'($urandom), {$urandom, $urandom});
      tick(1'b1);
      enable = '0;
      drive_req(0, 4'($urandom), 4'($urandom), {$urandom, $urandom});
      tick(1'b1);
      enable = '0;
      repeat (2) tick(1'b1);
      n_checks++; if (up_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_body: got %b want 1", up_valid); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if (up_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", up_valid); end
      n_checks++; if (ready !== 2'b11) begin n_fail++; $display("FAIL rstmid_ready: got %b want 11", ready); end
      n_checks++; if (overflow !== 2'b00) begin n_fail++; $display("FAIL rstmid_overflow: got %b want 00", overflow); end
      n_checks++; if (up_flit !== '0) begin n_fail++; $display("FAIL rstmid_flit: got %h want 0", up_flit); end
      @(negedge clk);
      rst = 1'b0;
      rr_ptr = 0;
      clear_logs();
      repeat (5) tick(1'b1);
      n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL rstmid_no_stale: got %0d flits want 0", got_q.size()); end
      dst = 4'($urandom); pad = 4'($urandom); pkt = {$urandom, $urandom};
      clear_logs();
      push_pkt(0, dst, pad, pkt);
      drive_req(0, dst, pad, pkt);
      tick(1'b1);
      enable = '0;
      tick(1'b1);
      n_checks++; if (up_valid !== 1'b1 || up_flit !== exp_q[0]) begin n_fail++; $display("FAIL rstmid_new_head: got %b/%h want 1/%h", up_valid, up_flit, exp_q[0]); end
      repeat (6) tick(1'b1);
      n_checks++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL rstmid_count: got %0d want 4", got_q.size()); end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_flit[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (ack_or !== 2'b01) begin n_fail++; $display("FAIL rstmid_ack: got %b want 01", ack_or); end
   endtask

   initial begin
      enable   = '0;
      dst_addr = '0;
      padding  = '0;
      packet   = '0;
      flush    = '0;
      up_ready = 1'b0;
      ack_or   = '0;
      test_reset();
      test_single();
      test_backpressure();
      test_contention();
      test_flush();
      test_overflow();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
